// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the D-MEM port arbiter.
// Holds the D-MEM geometry (data width, decoded byte-address bits, dropped byte-offset
// bits), the arbiter FSM state encoding, the read-owner encoding and the grant vector
// bit positions. Imported by the interface, the winner-select sub-module and the top.
package dmem_port_arbiter_pkg;

    localparam int unsigned DBITS        = 32;
    localparam int unsigned DMEMADDRBITS = 13;
    localparam int unsigned DMEMWORDBITS = 2;
    localparam int unsigned IDXBITS      = DMEMADDRBITS - DMEMWORDBITS;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_P     = 2'd1,
        ARB_D     = 2'd2,
        ARB_DLOCK = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Bit positions inside the two-bit grant vector.
    localparam int unsigned GNT_P = 0;
    localparam int unsigned GNT_D = 1;

    // Width of a counter that must hold 0..limit inclusive.
    function automatic int unsigned cnt_bits(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the D-MEM array.
//   p_*   : pipeline MEM-stage port (req/we/addr/wdata in, gnt/rvalid/rdata/stall out)
//   d_*   : debug/loader port (as P plus d_lock for bursts, no stall)
//   mem_* : D-MEM strobe, write enable, word index, write data and read data
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_port_arbiter_if;
    import dmem_port_arbiter_pkg::*;

    logic               p_req;
    logic               p_we;
    logic [DBITS-1:0]   p_addr;
    logic [DBITS-1:0]   p_wdata;
    logic               p_gnt;
    logic               p_rvalid;
    logic [DBITS-1:0]   p_rdata;
    logic               p_stall;

    logic               d_req;
    logic               d_we;
    logic [DBITS-1:0]   d_addr;
    logic [DBITS-1:0]   d_wdata;
    logic               d_lock;
    logic               d_gnt;
    logic               d_rvalid;
    logic [DBITS-1:0]   d_rdata;

    logic               mem_en;
    logic               mem_we;
    logic [IDXBITS-1:0] mem_idx;
    logic [DBITS-1:0]   mem_wdata;
    logic [DBITS-1:0]   mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_gnt, p_rvalid, p_rdata, p_stall,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_idx, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_gnt, p_rvalid, p_rdata, p_stall,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_idx, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the D-MEM arbiter.
// Inputs: p_req, d_req, current FSM state and either the starvation counter (default)
// or the last-granted pointer (when DMEM_ARB_RR_EN is defined).
// Output: gnt[GNT_P]/gnt[GNT_D], at most one set.
// Configuration macro: DMEM_ARB_RR_EN selects round-robin instead of fixed priority
// with starvation escape. A locked D burst wins in both builds.
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_BITS     = 3
) (
    input  logic                p_req,
    input  logic                d_req,
    input  arb_state_e          state,
`ifdef DMEM_ARB_RR_EN
    input  owner_e              rr_last,
`else
    input  logic [CNT_BITS-1:0] starve_cnt,
`endif
    output logic [1:0]          gnt
);

`ifndef DMEM_ARB_RR_EN
    localparam logic [CNT_BITS-1:0] Limit = CNT_BITS'(STARVE_LIMIT);
`endif

    logic d_wins_conflict;

`ifdef DMEM_ARB_RR_EN
    // The port granted most recently yields the next conflict.
    assign d_wins_conflict = (rr_last == OWN_P);
`else
    assign d_wins_conflict = (starve_cnt == Limit);
`endif

    always_comb begin
        gnt = 2'b00;
        if ((state == ARB_DLOCK) && d_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (p_req && !(d_req && d_wins_conflict)) begin
            gnt[GNT_P] = 1'b1;
        end else if (d_req) begin
            gnt[GNT_D] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port synchronous D-MEM between the pipeline MEM stage (P) and a
// debug/loader master (D).
// Ports: clk, reset (asynchronous, active-low), bus (dmem_port_arbiter_if.slave).
// Grants are combinational from the requests and registered state; read data returns
// one cycle after the grant and is routed by the registered owner.
// Configuration macro: DMEM_ARB_RR_EN (round-robin instead of fixed priority to P with
// a starvation counter guaranteeing D progress).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_BITS = cnt_bits(STARVE_LIMIT);

    arb_state_e state_q;
    owner_e     owner_q;
    logic       rd_pending_q;
    logic [1:0] win;
    logic       p_gnt;
    logic       d_gnt;

`ifdef DMEM_ARB_RR_EN
    owner_e rr_last_q;
`else
    localparam logic [CNT_BITS-1:0] Limit = CNT_BITS'(STARVE_LIMIT);
    logic [CNT_BITS-1:0] starve_cnt_q;
`endif

    dmem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_BITS     (CNT_BITS)
    ) u_pick (
        .p_req      (bus.p_req),
        .d_req      (bus.d_req),
        .state      (state_q),
`ifdef DMEM_ARB_RR_EN
        .rr_last    (rr_last_q),
`else
        .starve_cnt (starve_cnt_q),
`endif
        .gnt        (win)
    );

    // No grant while reset is held, so nothing reaches the array during reset.
    assign p_gnt = win[GNT_P] & reset;
    assign d_gnt = win[GNT_D] & reset;

    assign bus.p_gnt   = p_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.p_stall = bus.p_req & ~p_gnt;

    assign bus.mem_en    = p_gnt | d_gnt;
    assign bus.mem_we    = (p_gnt & bus.p_we) | (d_gnt & bus.d_we);
    assign bus.mem_idx   = d_gnt ? bus.d_addr[DMEMADDRBITS-1:DMEMWORDBITS]
                                 : bus.p_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : bus.p_wdata;

    assign bus.p_rvalid = rd_pending_q & (owner_q == OWN_P);
    assign bus.d_rvalid = rd_pending_q & (owner_q == OWN_D);
    assign bus.p_rdata  = bus.p_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

    // Address bits above the D-MEM range are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.p_addr[DBITS-1:DMEMADDRBITS], bus.p_addr[DMEMWORDBITS-1:0],
                           bus.d_addr[DBITS-1:DMEMADDRBITS], bus.d_addr[DMEMWORDBITS-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_P;
            rd_pending_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_last_q    <= OWN_D;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            rd_pending_q <= (p_gnt & ~bus.p_we) | (d_gnt & ~bus.d_we);
            if (p_gnt || d_gnt) begin
                owner_q <= d_gnt ? OWN_D : OWN_P;
            end

            // A locked D grant enters DLOCK directly so the burst's next beat cannot
            // be taken by P.
            unique case (state_q)
                ARB_DLOCK: state_q <= (bus.d_req && bus.d_lock) ? ARB_DLOCK : ARB_IDLE;
                default: begin
                    if (d_gnt) begin
                        state_q <= bus.d_lock ? ARB_DLOCK : ARB_D;
                    end else if (p_gnt) begin
                        state_q <= ARB_P;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
            endcase

`ifdef DMEM_ARB_RR_EN
            if (p_gnt) begin
                rr_last_q <= OWN_P;
            end else if (d_gnt) begin
                rr_last_q <= OWN_D;
            end
`else
            if (bus.d_req && !d_gnt) begin
                if (starve_cnt_q != Limit) begin
                    starve_cnt_q <= starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter: a behavioural synchronous D-MEM,
// a read scoreboard (expected data pushed on read grant, popped on rvalid) and
// per-cycle grant/stall/memory-drive checks. Honours DMEM_ARB_RR_EN where the
// expected grant order differs.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic        port;   // 1 = D, 0 = P
        logic [31:0] data;
    } rd_t;

    rd_t         sbq[$];
    logic [31:0] mem [0:2047];

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read, synchronous-write memory model; preloads index 0x10 in reset.
    always @(posedge clk) begin
        if (!reset) begin
            mem[16] <= 32'h0000_1234;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;
            else            bus.mem_rdata   <= mem[bus.mem_idx];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check rvalid/rdata against the scoreboard, then grants {p,d}, stall
    // and the memory drive; push expected data for a granted read.
    task automatic cyc(input logic [1:0] eg);
        rd_t         e;
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        @(negedge clk);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rvalid", 64'({bus.p_rvalid, bus.d_rvalid}), 64'(e.port ? 2'b01 : 2'b10));
            chk("rdata", 64'(e.port ? bus.d_rdata : bus.p_rdata), 64'(e.data));
        end else begin
            chk("no_rvalid", 64'({bus.p_rvalid, bus.d_rvalid}), 64'(0));
        end
        chk("gnt", 64'({bus.p_gnt, bus.d_gnt}), 64'(eg));
        chk("p_stall", 64'(bus.p_stall), 64'(bus.p_req & ~eg[1]));
        chk("mem_en", 64'(bus.mem_en), 64'(|eg));
        if (|eg) begin
            a  = eg[0] ? bus.d_addr : bus.p_addr;
            wd = eg[0] ? bus.d_wdata : bus.p_wdata;
            we = eg[0] ? bus.d_we : bus.p_we;
            chk("mem_we", 64'(bus.mem_we), 64'(we));
            chk("mem_idx", 64'(bus.mem_idx), 64'(a[12:2]));
            if (we) begin
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
            end else begin
                e.port = eg[0];
                e.data = mem[a[12:2]];
                sbq.push_back(e);
            end
        end else begin
            chk("mem_we_idle", 64'(bus.mem_we), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int np;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h40; bus.p_wdata = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'h0;
        bus.d_lock = 1'b0;

        // Reset: requests asserted but nothing may be granted or returned.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'({bus.p_gnt, bus.d_gnt}), 64'(0));
        chk("rst_mem", 64'({bus.mem_en, bus.mem_we}), 64'(0));
        chk("rst_rvalid", 64'({bus.p_rvalid, bus.d_rvalid}), 64'(0));
        chk("rst_rdata", 64'({bus.p_rdata, bus.d_rdata}), 64'(0));
        chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        bus.p_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // P read of 0x40 (index 0x10 holds 0x1234).
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h40;
        cyc(2'b10);
        chk("p_rd_1234", 64'(bus.p_rdata), 64'(32'h1234));
        bus.p_req = 1'b0;
        cyc(2'b00);

        // Continuous conflict.
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
`ifdef DMEM_ARB_RR_EN
        cyc(2'b10); cyc(2'b01); cyc(2'b10); cyc(2'b01);
`else
        repeat (4) cyc(2'b10);
        cyc(2'b01);
        chk("starve_clr", 64'(dut.starve_cnt_q), 64'(0));
`endif
        bus.p_req = 1'b0; bus.d_req = 1'b0;
        cyc(2'b00);

        // Locked D burst writing 0xA0..0xA3 to indices 0..3 against a requesting P.
`ifdef DMEM_ARB_RR_EN
        np = 1;
`else
        np = 4;
`endif
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h48;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b1;
        bus.d_addr = 32'h0; bus.d_wdata = 32'hA0;
        repeat (np) cyc(2'b10);
        for (int i = 0; i < 4; i++) begin
            bus.d_addr  = 32'(i * 4);
            bus.d_wdata = 32'hA0 + 32'(i);
            cyc(2'b01);
        end
        bus.d_req = 1'b0; bus.d_lock = 1'b0;
        bus.p_addr = 32'h8;
        cyc(2'b10);
        chk("burst_rd_a2", 64'(bus.p_rdata), 64'(32'hA2));
        bus.p_req = 1'b0;
        cyc(2'b00);

        // Write then read the same index back to back.
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h80; bus.p_wdata = 32'hDEADBEEF;
        cyc(2'b10);
        bus.p_we = 1'b0;
        cyc(2'b10);
        chk("raw_rdata", 64'(bus.p_rdata), 64'(32'hDEADBEEF));

        // Out-of-range address truncates to index 0x10.
        bus.p_addr = 32'h0001_2040;
        cyc(2'b10);
        chk("trunc_rdata", 64'(bus.p_rdata), 64'(32'h1234));
        bus.p_req = 1'b0;
        cyc(2'b00);

        // Reset lands while a D read is granted: the read is dropped.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        @(negedge clk);
        chk("mid_gnt", 64'(bus.d_gnt), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'({bus.p_gnt, bus.d_gnt, bus.mem_en}), 64'(0));
        chk("mid_rst_rvalid", 64'(bus.d_rvalid), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_rvalid2", 64'(bus.d_rvalid), 64'(0));
        bus.d_req = 1'b0;
        reset = 1'b1;
        chk("post_state", 64'(dut.state_q), 64'(ARB_IDLE));
`ifndef DMEM_ARB_RR_EN
        chk("post_starve", 64'(dut.starve_cnt_q), 64'(0));
`endif
        cyc(2'b00);
        cyc(2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
